// File: rtl/kick_scheduler.sv
// Kicker solenoid arbiter: grants one of two requesters a fixed-width pulse, then enforces a cooldown.
// Optional KICK_BALL_GATE_EN adds a synchronized ball_present input that must be 1 for a grant.
module kick_scheduler #(
    parameter int PULSE_CYC = 8,
    parameter int COOL_CYC  = 64,
    parameter int CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic [1:0] req,
    input  logic       abort,
`ifdef KICK_BALL_GATE_EN
    input  logic       ball_present,
`endif
    output logic [1:0] grant,
    output logic       kick,
    output logic [1:0] done,
    output logic       busy
);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LD  = CNT_W'(COOL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       grant_nxt, done_nxt;
    logic             kick_nxt, busy_nxt;
    logic             rr_last, rr_last_nxt;
    logic [1:0]       deny_cnt, deny_nxt;
    logic             gate_ok;
    logic             pick_manual;

`ifdef KICK_BALL_GATE_EN
    logic [1:0] ball_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_sync <= 2'b00;
        end else begin
            ball_sync <= {ball_sync[0], ball_present};
        end
    end

    assign gate_ok = ball_sync[1];
`else
    assign gate_ok = 1'b1;
`endif

    // Manual wins ties unless the autonomous side has already lost two grants in a row.
    assign pick_manual = req[1] && !(req[0] && (deny_cnt == 2'd2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            grant    <= 2'b00;
            kick     <= 1'b0;
            done     <= 2'b00;
            busy     <= 1'b0;
            rr_last  <= 1'b1;
            deny_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            grant    <= grant_nxt;
            kick     <= kick_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
            rr_last  <= rr_last_nxt;
            deny_cnt <= deny_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        grant_nxt   = grant;
        kick_nxt    = kick;
        done_nxt    = 2'b00;
        busy_nxt    = busy;
        rr_last_nxt = rr_last;
        deny_nxt    = deny_cnt;
        case (state)
            IDLE: begin
                if (arm && gate_ok && (|req)) begin
                    rr_last_nxt = pick_manual;
                    grant_nxt   = pick_manual ? 2'b10 : 2'b01;
                    kick_nxt    = 1'b1;
                    busy_nxt    = 1'b1;
                    cnt_nxt     = PULSE_LD;
                    state_nxt   = FIRE;
                    deny_nxt    = (pick_manual && req[0]) ? deny_cnt + 2'd1 : 2'd0;
                end
            end
            FIRE: begin
                // Abort coinciding with terminal count takes this same single exit.
                if ((cnt == '0) || abort) begin
                    kick_nxt  = 1'b0;
                    grant_nxt = 2'b00;
                    done_nxt  = rr_last ? 2'b10 : 2'b01;
                    cnt_nxt   = COOL_LD;
                    state_nxt = COOL;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            COOL: begin
                if (cnt == '0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                grant_nxt = 2'b00;
                kick_nxt  = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_kick_scheduler.sv
// Directed bench for kick_scheduler (PULSE_CYC=8, COOL_CYC=64, default build without ball gate).
module tb_kick_scheduler;

    logic       clk;
    logic       rst_n;
    logic       arm;
    logic [1:0] req;
    logic       abort;
    logic [1:0] grant;
    logic       kick;
    logic [1:0] done;
    logic       busy;

    int ncmp = 0;
    int nbad = 0;

    kick_scheduler #(
        .PULSE_CYC(8),
        .COOL_CYC (64),
        .CNT_W    (26)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .arm  (arm),
        .req  (req),
        .abort(abort),
        .grant(grant),
        .kick (kick),
        .done (done),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       arm;
        logic [1:0] req;
        logic       abort;
        logic [1:0] g;
        logic       k;
        logic [1:0] d;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic a, input logic [1:0] r, input logic ab,
                                input logic [1:0] g, input logic k, input logic [1:0] d,
                                input logic b);
        vec_t v;
        v.n = n; v.arm = a; v.req = r; v.abort = ab;
        v.g = g; v.k = k; v.d = d; v.b = b;
        tbl.push_back(v);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got grant=%b kick=%b done=%b busy=%b, expected grant=%b kick=%b done=%b busy=%b",
                     name, act[5:4], act[3], act[2:1], act[0], exp[5:4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Steps until kick rises; cyc reports cycles taken, or -1 if the bound expires.
    task automatic wait_rise(output int cyc);
        logic pk;
        pk  = kick;
        cyc = -1;
        for (int c = 1; c <= 200; c++) begin
            step(1);
            if (kick && !pk) begin
                cyc = c;
                break;
            end
            pk = kick;
        end
    endtask

    initial begin
        int iv;
        int dones;

        rst_n = 1'b0; arm = 1'b0; req = 2'b00; abort = 1'b0;
        #1;
        check("reset_async", {grant, kick, done, busy}, 6'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("reset_release", {grant, kick, done, busy}, 6'b0);

        // n, arm, req, abort | grant, kick, done, busy
        add(1,  1, 2'b01, 0, 2'b01, 1, 2'b00, 1);   // basic shot: grant in 1 cycle
        add(7,  1, 2'b01, 0, 2'b01, 1, 2'b00, 1);   // 8th kick cycle
        add(1,  1, 2'b01, 0, 2'b00, 0, 2'b01, 1);   // done to requester 0
        add(1,  1, 2'b00, 0, 2'b00, 0, 2'b00, 1);
        add(62, 1, 2'b00, 0, 2'b00, 0, 2'b00, 1);   // 63 cycles after done, still cooling
        add(1,  1, 2'b00, 0, 2'b00, 0, 2'b00, 0);   // 64 after done: idle
        add(1,  1, 2'b11, 0, 2'b10, 1, 2'b00, 1);   // tie 1 -> manual
        add(8,  1, 2'b11, 0, 2'b00, 0, 2'b10, 1);
        add(64, 1, 2'b11, 0, 2'b00, 0, 2'b00, 0);   // req ignored through cooldown
        add(1,  1, 2'b11, 0, 2'b10, 1, 2'b00, 1);   // tie 2 -> manual
        add(8,  1, 2'b11, 0, 2'b00, 0, 2'b10, 1);
        add(64, 1, 2'b11, 0, 2'b00, 0, 2'b00, 0);
        add(1,  1, 2'b11, 0, 2'b01, 1, 2'b00, 1);   // tie 3 -> starvation guard
        add(8,  1, 2'b11, 0, 2'b00, 0, 2'b01, 1);
        add(64, 1, 2'b00, 0, 2'b00, 0, 2'b00, 0);
        add(1,  1, 2'b01, 0, 2'b01, 1, 2'b00, 1);   // FIRE cycle 1
        add(2,  1, 2'b01, 0, 2'b01, 1, 2'b00, 1);   // FIRE cycle 3
        add(1,  1, 2'b01, 1, 2'b00, 0, 2'b01, 1);   // abort: kick low, done
        add(1,  1, 2'b00, 0, 2'b00, 0, 2'b00, 1);
        add(62, 1, 2'b00, 0, 2'b00, 0, 2'b00, 1);   // full cooldown after abort
        add(1,  1, 2'b00, 0, 2'b00, 0, 2'b00, 0);
        add(1,  1, 2'b00, 1, 2'b00, 0, 2'b00, 0);   // abort in idle: no effect
        add(3,  0, 2'b01, 0, 2'b00, 0, 2'b00, 0);   // arm=0 blocks grant
        add(1,  1, 2'b01, 0, 2'b01, 1, 2'b00, 1);
        add(7,  0, 2'b01, 0, 2'b01, 1, 2'b00, 1);   // arm drop does not cut pulse
        add(1,  0, 2'b01, 0, 2'b00, 0, 2'b01, 1);
        add(64, 0, 2'b01, 0, 2'b00, 0, 2'b00, 0);
        add(2,  0, 2'b01, 0, 2'b00, 0, 2'b00, 0);   // waits for arm
        add(1,  1, 2'b01, 0, 2'b01, 1, 2'b00, 1);
        add(7,  1, 2'b01, 0, 2'b01, 1, 2'b00, 1);   // terminal-count cycle
        add(1,  1, 2'b01, 1, 2'b00, 0, 2'b01, 1);   // abort at terminal count: one done
        add(1,  1, 2'b01, 0, 2'b00, 0, 2'b00, 1);   // no second done

        foreach (tbl[i]) begin
            arm   = tbl[i].arm;
            req   = tbl[i].req;
            abort = tbl[i].abort;
            step(tbl[i].n);
            check($sformatf("vec%0d", i), {grant, kick, done, busy},
                  {tbl[i].g, tbl[i].k, tbl[i].d, tbl[i].b});
        end

        // Continuous request: rising edges of kick spaced PULSE+COOL+1.
        abort = 1'b0; arm = 1'b1; req = 2'b01;
        wait_rise(iv);
        check_int("first_rise_seen", (iv > 0) ? 1 : 0, 1);
        wait_rise(iv);
        check_int("spacing_1", iv, 73);
        wait_rise(iv);
        check_int("spacing_2", iv, 73);

        // Reset mid-FIRE: kick drops without waiting for a clock edge.
        step(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid_fire", {grant, kick, done, busy}, 6'b0);
        req = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (done != 2'b00 || kick) dones++;
        end
        check_int("no_done_after_reset", dones, 0);
        req = 2'b01;
        step(1);
        check("idle_after_reset", {grant, kick, done, busy}, 6'b011001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
